// File: rtl/alu_shift_add_multiplier.sv
// Shift-and-add multiplier that borrows an external ALU for every add and shift.
// Produces the low N bits of multiplicand * multiplier over valid/ready handshakes.

package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_control_t;
endpackage

module alu_shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_control_t alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SRL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_mcand;
    logic [N-1:0] r_mplier;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    alu_control_t r_alu_control;

    state_t       w_state_nxt;
    logic [N-1:0] w_acc_nxt;
    logic [N-1:0] w_mcand_nxt;
    logic [N-1:0] w_mplier_nxt;
    logic [N-1:0] w_alu_a_nxt;
    logic [N-1:0] w_alu_b_nxt;
    alu_control_t w_alu_control_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc_nxt    = '0;
                    w_mcand_nxt  = multiplicand;
                    w_mplier_nxt = multiplier;
                    w_state_nxt  = multiplier[0] ? S_ADD : S_SHL;
                end
            end
            S_ADD: begin
                w_acc_nxt   = alu_result;
                w_state_nxt = S_SHL;
            end
            S_SHL: begin
                w_mcand_nxt = alu_result;
                w_state_nxt = S_SRL;
            end
            S_SRL: begin
                w_mplier_nxt = alu_result;
                if (alu_zero) begin
                    w_state_nxt = S_DONE;
                end else if (alu_result[0]) begin
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_SHL;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU drive is precomputed for the state being entered, so the ports come straight from flops.
    always_comb begin
        w_alu_control_nxt = ALU_ADD;
        w_alu_a_nxt       = '0;
        w_alu_b_nxt       = '0;
        case (w_state_nxt)
            S_ADD: begin
                w_alu_control_nxt = ALU_ADD;
                w_alu_a_nxt       = w_acc_nxt;
                w_alu_b_nxt       = w_mcand_nxt;
            end
            S_SHL: begin
                w_alu_control_nxt = ALU_SLL;
                w_alu_a_nxt       = w_mcand_nxt;
                w_alu_b_nxt       = ONE;
            end
            S_SRL: begin
                w_alu_control_nxt = ALU_SRL;
                w_alu_a_nxt       = w_mplier_nxt;
                w_alu_b_nxt       = ONE;
            end
            default: begin
                w_alu_control_nxt = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= ALU_ADD;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_mcand       <= w_mcand_nxt;
            r_mplier      <= w_mplier_nxt;
            r_in_ready    <= (w_state_nxt == S_IDLE);
            r_out_valid   <= (w_state_nxt == S_DONE);
            r_alu_a       <= w_alu_a_nxt;
            r_alu_b       <= w_alu_b_nxt;
            r_alu_control <= w_alu_control_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign product     = r_acc;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_shift_add_multiplier.sv
// Bench for alu_shift_add_multiplier: behavioural ALU on the ALU ports, a
// cycle-count/product model checked every cycle, and directed literal vectors.

module tb_alu_shift_add_multiplier;
    import alu_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  multiplicand;
    logic [31:0]  multiplier;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  product;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    alu_control_t alu_control;
    logic [31:0]  alu_result;
    logic         alu_zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_shift_add_multiplier #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLL: alu_result = alu_a << alu_b[4:0];
            ALU_SRL: alu_result = alu_a >> alu_b[4:0];
            ALU_SRA: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: latency from the highest set bit and popcount, product as plain truncated multiply.
    function automatic int model_latency(input logic [31:0] m);
        int k = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) k = i;
        end
        return 2 * (k + 1) + $countones(m);
    endfunction

    typedef enum {M_IDLE, M_BUSY, M_DONE} m_phase_t;
    m_phase_t    m_phase;
    int          m_left;
    logic [31:0] m_prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= M_IDLE;
            m_left  <= 0;
            m_prod  <= 32'd0;
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    m_phase <= M_BUSY;
                    m_left  <= model_latency(multiplier);
                    m_prod  <= multiplicand * multiplier;
                end
                M_BUSY: if (m_left == 1) m_phase <= M_DONE;
                        else m_left <= m_left - 1;
                M_DONE: if (out_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp in_ready", 32'(in_ready), 32'(m_phase == M_IDLE));
            check("cmp out_valid", 32'(out_valid), 32'(m_phase == M_DONE));
            if (m_phase == M_DONE) check("cmp product", product, m_prod);
            if (m_phase != M_BUSY) begin
                check("cmp alu_control idle", 32'(alu_control), 32'(ALU_ADD));
                check("cmp alu_a idle", alu_a, 32'd0);
                check("cmp alu_b idle", alu_b, 32'd0);
            end
        end
    end

    alu_control_t ctl_log[$];
    logic         saw_ready;

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        ctl_log.delete();
        saw_ready = 1'b0;
        while (out_valid !== 1'b1 && cycles < 400) begin
            ctl_log.push_back(alu_control);
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done within budget", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consume out_valid low", 32'(out_valid), 32'd0);
        check("consume in_ready high", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_prod, input int exp_lat);
        int c;
        start(a, b);
        wait_done(c);
        check({name, " latency"}, 32'(c), 32'(exp_lat));
        check({name, " product"}, product, exp_prod);
        check({name, " in_ready low while busy"}, 32'(saw_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_control_t exp_seq[8];
        int c;
        int n_add;
        exp_seq = '{ALU_ADD, ALU_SLL, ALU_SRL, ALU_SLL, ALU_SRL, ALU_ADD, ALU_SLL, ALU_SRL};

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset product", product, 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset alu_control", 32'(alu_control), 32'(ALU_ADD));
        @(negedge clk);
        rst = 1'b0;

        run_mul("3*5", 32'd3, 32'd5, 32'd15, 8);
        check("3*5 alu op count", 32'(ctl_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ctl_log.size()) check("3*5 alu op sequence", 32'(ctl_log[i]), 32'(exp_seq[i]));
        end
        consume();

        run_mul("12345*0", 32'd12345, 32'd0, 32'd0, 2);
        n_add = 0;
        foreach (ctl_log[i]) if (ctl_log[i] == ALU_ADD) n_add++;
        check("12345*0 no add issued", 32'(n_add), 32'd0);
        consume();

        run_mul("-7*6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 8);
        consume();

        run_mul("max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 96);
        consume();

        // Back-pressure: product holds and new requests are ignored until consumed.
        run_mul("9*9", 32'd9, 32'd9, 32'd81, 10);
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold product", product, 32'd81);
            check("hold in_ready", 32'(in_ready), 32'd0);
            check("hold out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release out_valid low", 32'(out_valid), 32'd0);
        check("release in_ready high", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pending request accepted", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(c);
        check("7*3 latency", 32'(c), 32'd6);
        check("7*3 product", product, 32'd21);
        consume();

        // Asynchronous abort in the middle of a long multiply.
        start(32'h0000_FFFF, 32'h0000_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort product", product, 32'd0);
        check("abort alu_a", alu_a, 32'd0);
        check("abort alu_b", alu_b, 32'd0);
        check("abort alu_control", 32'(alu_control), 32'(ALU_ADD));
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort out_valid held", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("after abort no out_valid", 32'(out_valid), 32'd0);
        end

        run_mul("2*2", 32'd2, 32'd2, 32'd4, 5);
        consume();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
